dmux_n_reg: RTL and testbench

Parametrised, registered 1-to-N demultiplexer: the next generation of the 1-to-2 combinational DMux. One input word is routed to one of `WAYS` output lanes chosen by `sel`. Input and outputs use a valid/ready handshake, and a single holding register gives one cycle of latency. Unselected lanes read zero, matching DMux semantics. It sits between a producer and up to `WAYS` consumers in the datapath.

---
 rtl/dmux_n_reg.sv | 132 +++++++++++++
 tb/tb_dmux_n_reg.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmux_n_reg.sv
// dmux_n_reg -- registered 1-to-WAYS demultiplexer with valid/ready handshake.
//
// One input word is steered to the output lane chosen by sel and held in a
// single holding register. That register gives one cycle of latency, and a
// same-cycle drain and refill sustains one word per cycle. Lanes that are not
// valid read zero. A word whose sel is out of range (sel >= WAYS) is accepted
// and discarded, and it sets the sticky drop_err flag.
//
// Parameters
//   WIDTH  data word width in bits (>= 1)
//   WAYS   number of output lanes (>= 2, need not be a power of two)
//   SEL_W  select width, derived from WAYS
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in         input data word
//   sel        destination lane for in
//   in_valid   producer offers in/sel
//   in_ready   block accepts this cycle (combinational from out_ready)
//   out        WAYS lanes, lane k at bits [k*WIDTH +: WIDTH], zero unless valid
//   out_valid  one-hot or zero, lane k holds a word
//   out_ready  consumer k accepts lane k
//   drop_err   sticky, an out-of-range sel was accepted
module dmux_n_reg #(
  parameter  int WIDTH = 16,
  parameter  int WAYS  = 4,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WAYS*WIDTH-1:0] out,
  output logic [WAYS-1:0]       out_valid,
  input  logic [WAYS-1:0]       out_ready,
  output logic                  drop_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Returns 1 when s names an existing lane. This is always true when WAYS is a
  // power of two.
  function automatic logic lane_in_range(input logic [SEL_W-1:0] s);
    return ({1'b0, s} < (SEL_W+1)'(WAYS));
  endfunction

  // Returns the ready bit of lane l. A decode loop is used here rather than a
  // direct index so that no index can fall past the top of rdy.
  function automatic logic lane_ready(input logic [SEL_W-1:0] l,
                                      input logic [WAYS-1:0]  rdy);
    logic r;
    r = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (l == SEL_W'(k)) r = rdy[k];
    end
    return r;
  endfunction

  state_t           state_p0;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_p0;
  logic [SEL_W-1:0] lane_p0;
  logic             drop_p0;

  logic             vld_p0;
  logic             drain;
  logic             take;
  logic             take_keep;
  logic             take_drop;

  // ---- input handshake / accept stage ----
  assign vld_p0    = (state_p0 == FULL);
  assign drain     = vld_p0 && lane_ready(lane_p0, out_ready);
  assign in_ready  = !reset && (!vld_p0 || drain);
  assign take      = in_valid && in_ready;
  assign take_keep = take && lane_in_range(sel);
  assign take_drop = take && !lane_in_range(sel);

  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      EMPTY: begin
        if (take_keep) state_nxt = FULL;
      end
      FULL: begin
        // An out-of-range word that replaces a draining one leaves us empty.
        if (drain) state_nxt = take_keep ? FULL : EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= EMPTY;
      drop_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      drop_p0  <= drop_p0 | take_drop;
    end
  end

  // The data and the lane are not reset, because out_valid and out are gated
  // by the state bit.
  always_ff @(posedge clk) begin
    if (take_keep) begin
      data_p0 <= in;
      lane_p0 <= sel;
    end
  end

  // ---- holding register / output decode stage ----
  always_comb begin
    out_valid = '0;
    out       = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (vld_p0 && (lane_p0 == SEL_W'(k))) begin
        out_valid[k]               = 1'b1;
        out[k*WIDTH +: WIDTH]      = data_p0;
      end
    end
  end

  assign drop_err = drop_p0;

endmodule

// File: tb/tb_dmux_n_reg.sv
module tb_dmux_n_reg;

  typedef struct {
    logic        rst;
    logic [15:0] din;
    logic [1:0]  sel;
    logic        iv;
    logic [3:0]  ordy;
    logic        exp_ir;
    logic [3:0]  exp_ov;
    logic [63:0] exp_out;
    logic        exp_drop;
  } vec_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with WAYS=4
  logic        rst4, iv4, ir4, drop4;
  logic [15:0] in4;
  logic [1:0]  sel4;
  logic [63:0] out4;
  logic [3:0]  ov4, or4;

  // DUT with WAYS=3
  logic        rst3, iv3, ir3, drop3;
  logic [15:0] in3;
  logic [1:0]  sel3;
  logic [47:0] out3;
  logic [2:0]  ov3, or3;

  dmux_n_reg #(.WIDTH(16), .WAYS(4)) u4 (
    .clk(clk), .reset(rst4), .in(in4), .sel(sel4), .in_valid(iv4),
    .in_ready(ir4), .out(out4), .out_valid(ov4), .out_ready(or4),
    .drop_err(drop4)
  );

  dmux_n_reg #(.WIDTH(16), .WAYS(3)) u3 (
    .clk(clk), .reset(rst3), .in(in3), .sel(sel3), .in_valid(iv3),
    .in_ready(ir3), .out(out3), .out_valid(ov3), .out_ready(or3),
    .drop_err(drop3)
  );

  int checks   = 0;
  int failures = 0;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [15:0] din, logic [1:0] sel,
                              logic iv, logic [3:0] ordy, logic exp_ir,
                              logic [3:0] exp_ov, logic [63:0] exp_out,
                              logic exp_drop);
    vec_t v;
    v.rst = rst; v.din = din; v.sel = sel; v.iv = iv; v.ordy = ordy;
    v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_out = exp_out;
    v.exp_drop = exp_drop;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Applies one vector to the selected DUT. in_ready is checked before the
  // edge, and the registered outputs are checked just after it.
  task automatic run(int dut, vec_t v, string nm);
    @(negedge clk);
    if (dut == 4) begin
      rst4 = v.rst; in4 = v.din; sel4 = v.sel; iv4 = v.iv; or4 = v.ordy;
    end else begin
      rst3 = v.rst; in3 = v.din; sel3 = v.sel; iv3 = v.iv; or3 = v.ordy[2:0];
    end
    #1;
    chk({nm, ".in_ready"}, (dut == 4) ? 64'(ir4) : 64'(ir3), 64'(v.exp_ir));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, (dut == 4) ? 64'(ov4) : 64'(ov3), 64'(v.exp_ov));
    chk({nm, ".out"}, (dut == 4) ? out4 : 64'(out3), v.exp_out);
    chk({nm, ".drop_err"}, (dut == 4) ? 64'(drop4) : 64'(drop3), 64'(v.exp_drop));
  endtask

  initial begin
    rst4 = 1'b1; in4 = '0; sel4 = '0; iv4 = 1'b0; or4 = '0;
    rst3 = 1'b1; in3 = '0; sel3 = '0; iv3 = 1'b0; or3 = '0;

    // rst din sel iv ordy | ir ov out drop
    // Reset with in_valid high, then release.
    tbl.push_back(mk(1, 16'h9999, 2'd1, 1, 4'b1111, 0, 4'b0000, 64'h0, 0));
    tbl.push_back(mk(1, 16'h9999, 2'd1, 1, 4'b1111, 0, 4'b0000, 64'h0, 0));
    tbl.push_back(mk(0, 16'h0000, 2'd0, 0, 4'b1111, 1, 4'b0000, 64'h0, 0));
    // Basic route to lane 2.
    tbl.push_back(mk(0, 16'hA5A5, 2'd2, 1, 4'b1111, 1, 4'b0100, 64'h0000_A5A5_0000_0000, 0));
    tbl.push_back(mk(0, 16'h0000, 2'd0, 0, 4'b1111, 1, 4'b0000, 64'h0, 0));
    // Streaming of words 1..8 over lanes 0,1,2,3,0,1,2,3.
    tbl.push_back(mk(0, 16'h0001, 2'd0, 1, 4'b1111, 1, 4'b0001, 64'h0000_0000_0000_0001, 0));
    tbl.push_back(mk(0, 16'h0002, 2'd1, 1, 4'b1111, 1, 4'b0010, 64'h0000_0000_0002_0000, 0));
    tbl.push_back(mk(0, 16'h0003, 2'd2, 1, 4'b1111, 1, 4'b0100, 64'h0000_0003_0000_0000, 0));
    tbl.push_back(mk(0, 16'h0004, 2'd3, 1, 4'b1111, 1, 4'b1000, 64'h0004_0000_0000_0000, 0));
    tbl.push_back(mk(0, 16'h0005, 2'd0, 1, 4'b1111, 1, 4'b0001, 64'h0000_0000_0000_0005, 0));
    tbl.push_back(mk(0, 16'h0006, 2'd1, 1, 4'b1111, 1, 4'b0010, 64'h0000_0000_0006_0000, 0));
    tbl.push_back(mk(0, 16'h0007, 2'd2, 1, 4'b1111, 1, 4'b0100, 64'h0000_0007_0000_0000, 0));
    tbl.push_back(mk(0, 16'h0008, 2'd3, 1, 4'b1111, 1, 4'b1000, 64'h0008_0000_0000_0000, 0));
    tbl.push_back(mk(0, 16'h0000, 2'd0, 0, 4'b1111, 1, 4'b0000, 64'h0, 0));
    // Back-pressure on lane 1; ready on lanes that are not valid is ignored.
    tbl.push_back(mk(0, 16'h1234, 2'd1, 1, 4'b0000, 1, 4'b0010, 64'h0000_0000_1234_0000, 0));
    tbl.push_back(mk(0, 16'h5678, 2'd3, 1, 4'b0000, 0, 4'b0010, 64'h0000_0000_1234_0000, 0));
    tbl.push_back(mk(0, 16'h5678, 2'd3, 1, 4'b1101, 0, 4'b0010, 64'h0000_0000_1234_0000, 0));
    tbl.push_back(mk(0, 16'h5678, 2'd3, 1, 4'b0000, 0, 4'b0010, 64'h0000_0000_1234_0000, 0));
    tbl.push_back(mk(0, 16'h5678, 2'd3, 1, 4'b0010, 1, 4'b1000, 64'h5678_0000_0000_0000, 0));
    tbl.push_back(mk(0, 16'h0000, 2'd0, 0, 4'b1000, 1, 4'b0000, 64'h0, 0));
    // Same-lane drain and refill, with no bubble.
    tbl.push_back(mk(0, 16'h1111, 2'd0, 1, 4'b0000, 1, 4'b0001, 64'h0000_0000_0000_1111, 0));
    tbl.push_back(mk(0, 16'h2222, 2'd0, 1, 4'b0001, 1, 4'b0001, 64'h0000_0000_0000_2222, 0));
    tbl.push_back(mk(0, 16'h0000, 2'd0, 0, 4'b0001, 1, 4'b0000, 64'h0, 0));
    // sel and in are ignored while in_valid is low.
    tbl.push_back(mk(0, 16'hFFFF, 2'd3, 0, 4'b0000, 1, 4'b0000, 64'h0, 0));

    for (int i = 0; i < tbl.size(); i++) run(4, tbl[i], $sformatf("vec%0d", i));

    // Reset while a word is held: the word is discarded, never delivered.
    run(4, mk(0, 16'hBEEF, 2'd0, 1, 4'b0000, 1, 4'b0001, 64'h0000_0000_0000_BEEF, 0), "mr_load");
    run(4, mk(1, 16'h7777, 2'd2, 1, 4'b0000, 0, 4'b0000, 64'h0, 0), "mr_reset");
    run(4, mk(0, 16'h0000, 2'd0, 0, 4'b1111, 1, 4'b0000, 64'h0, 0), "mr_after");
    run(4, mk(0, 16'h4242, 2'd3, 1, 4'b1111, 1, 4'b1000, 64'h4242_0000_0000_0000, 0), "mr_next");
    run(4, mk(0, 16'h0000, 2'd0, 0, 4'b1111, 1, 4'b0000, 64'h0, 0), "mr_idle");

    // WAYS=3: an out-of-range sel is dropped and drop_err is sticky.
    run(3, mk(1, 16'h0000, 2'd0, 0, 4'b0111, 0, 4'b000, 64'h0, 0), "w3_reset");
    run(3, mk(0, 16'hFFFF, 2'd3, 1, 4'b0111, 1, 4'b000, 64'h0, 1), "w3_oor");
    for (int j = 1; j <= 10; j++) begin
      logic [1:0] s;
      s = 2'((j - 1) % 3);
      run(3, mk(0, 16'(j), s, 1, 4'b0111, 1, 4'(1 << s),
                64'(j) << (16 * s), 1), $sformatf("w3_xfer%0d", j));
    end
    run(3, mk(0, 16'h0000, 2'd0, 0, 4'b0111, 1, 4'b000, 64'h0, 1), "w3_idle");
    // A dropped word that replaces a draining one leaves the block empty.
    run(3, mk(0, 16'hAAAA, 2'd1, 1, 4'b0000, 1, 4'b010, 64'h0000_0000_AAAA_0000, 1), "w3_hold");
    run(3, mk(0, 16'hBBBB, 2'd3, 1, 4'b0010, 1, 4'b000, 64'h0, 1), "w3_replace");
    run(3, mk(1, 16'hCCCC, 2'd0, 1, 4'b0111, 0, 4'b000, 64'h0, 0), "w3_clear");
    run(3, mk(0, 16'h0000, 2'd0, 0, 4'b0111, 1, 4'b000, 64'h0, 0), "w3_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
